// File: rtl/_uart_pkg.sv
// Shared UART definitions: frame FSM states, line constants and parity helper.
// Reused by the transmitter and the future receiver.
package _uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

  function automatic logic parity_acc(input logic acc, input logic data_bit);
    return acc ^ data_bit;
  endfunction

endpackage

// File: rtl/_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1, wraps, and flags the terminal
// count plus the cycle just before it (used to register the done pulse).
module _baud_tick #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic _clock,
  input  logic _reset,
  input  logic _clear,
  output logic _tick,
  output logic _pre_tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST     = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] PRE_LAST = CW'(CLKS_PER_BIT - 2);

  logic [CW-1:0] count_r;

  // baud counter with synchronous clear and wrap at terminal count
  always_ff @(posedge _clock or negedge _reset) begin
    if (!_reset) begin
      count_r <= '0;
    end else if (_clear || (count_r == LAST)) begin
      count_r <= '0;
    end else begin
      count_r <= count_r + CW'(1);
    end
  end

  assign _tick     = (count_r == LAST);
  assign _pre_tick = (count_r == PRE_LAST);

endmodule

// File: rtl/_uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional even parity, one stop bit.
// Line, busy and done are registered from the next-state values so they align with the FSM.
module _uart_tx
  import _uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter bit PARITY_EN    = 1'b0
) (
  input  logic       _clock,
  input  logic       _reset,
  input  logic       _enable,
  input  logic       _valid,
  input  logic [7:0] _letter,
  output logic       _ready,
  output logic       _tx,
  output logic       _busy,
  output logic       _done
);

  localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

  uart_state_t               state_r, next_state_s;
  logic [UART_DATA_BITS-1:0] shift_r, shift_s;
  logic [2:0]                bit_cnt_r, bit_cnt_s;
  logic                      parity_r, parity_s;
  logic                      tick_s, pre_tick_s, clear_s;
  logic                      ready_s, transfer_s;
  logic                      tx_r, busy_r, done_r;
  logic                      tx_s, busy_s, done_s;

  // Ready is gated by reset so it reads 0 while the async reset is held.
  assign ready_s    = _reset & _enable & ((state_r == IDLE) | ((state_r == STOP) & tick_s));
  assign transfer_s = _valid & ready_s;
  assign clear_s    = (state_r == IDLE) | transfer_s;

  _baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    ._clock    (_clock),
    ._reset    (_reset),
    ._clear    (clear_s),
    ._tick     (tick_s),
    ._pre_tick (pre_tick_s)
  );

  // state register
  always_ff @(posedge _clock or negedge _reset) begin
    if (!_reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // next-state and datapath next values
  always_comb begin
    next_state_s = state_r;
    shift_s      = shift_r;
    bit_cnt_s    = bit_cnt_r;
    parity_s     = parity_r;
    case (state_r)
      IDLE: begin
        if (transfer_s) begin
          next_state_s = START;
          shift_s      = _letter;
          bit_cnt_s    = 3'd0;
          parity_s     = 1'b0;
        end else begin
          next_state_s = IDLE;
        end
      end
      START: begin
        if (tick_s) begin
          next_state_s = DATA;
        end else begin
          next_state_s = START;
        end
      end
      DATA: begin
        if (tick_s) begin
          parity_s  = parity_acc(parity_r, shift_r[0]);
          shift_s   = {1'b0, shift_r[UART_DATA_BITS-1:1]};
          bit_cnt_s = bit_cnt_r + 3'd1;
          if (bit_cnt_r != LAST_BIT) begin
            next_state_s = DATA;
          end else if (PARITY_EN) begin
            next_state_s = PARITY;
          end else begin
            next_state_s = STOP;
          end
        end else begin
          next_state_s = DATA;
        end
      end
      PARITY: begin
        if (tick_s) begin
          next_state_s = STOP;
        end else begin
          next_state_s = PARITY;
        end
      end
      STOP: begin
        if (tick_s && transfer_s) begin
          next_state_s = START;
          shift_s      = _letter;
          bit_cnt_s    = 3'd0;
          parity_s     = 1'b0;
        end else if (tick_s) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = STOP;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // output values for the upcoming cycle
  always_comb begin
    tx_s = UART_IDLE_LEVEL;
    case (next_state_s)
      START:     tx_s = 1'b0;
      DATA:      tx_s = shift_s[0];
      PARITY:    tx_s = parity_s;
      STOP:      tx_s = UART_IDLE_LEVEL;
      IDLE:      tx_s = UART_IDLE_LEVEL;
      default:   tx_s = UART_IDLE_LEVEL;
    endcase
    busy_s = (next_state_s != IDLE);
    done_s = (state_r == STOP) && pre_tick_s;
  end

  // datapath registers
  always_ff @(posedge _clock or negedge _reset) begin
    if (!_reset) begin
      shift_r   <= '0;
      bit_cnt_r <= 3'd0;
      parity_r  <= 1'b0;
    end else begin
      shift_r   <= shift_s;
      bit_cnt_r <= bit_cnt_s;
      parity_r  <= parity_s;
    end
  end

  // registered outputs
  always_ff @(posedge _clock or negedge _reset) begin
    if (!_reset) begin
      tx_r   <= UART_IDLE_LEVEL;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      tx_r   <= tx_s;
      busy_r <= busy_s;
      done_r <= done_s;
    end
  end

  assign _ready = ready_s;
  assign _tx    = tx_r;
  assign _busy  = busy_r;
  assign _done  = done_r;

endmodule

// File: tb/tb__uart_tx.sv
// Self-checking bench for _uart_tx: a plain-parity DUT and a parity-enabled DUT,
// checked cycle by cycle against a frame-bit reference model.
module tb__uart_tx;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       valid_n, valid_p;
  logic [7:0] letter;
  logic       ready_n, tx_n, busy_n, done_n;
  logic       ready_p, tx_p, busy_p, done_p;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  _uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b0)) dut (
    ._clock(clk), ._reset(rst_n), ._enable(enable), ._valid(valid_n), ._letter(letter),
    ._ready(ready_n), ._tx(tx_n), ._busy(busy_n), ._done(done_n)
  );

  _uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1'b1)) dut_p (
    ._clock(clk), ._reset(rst_n), ._enable(enable), ._valid(valid_p), ._letter(letter),
    ._ready(ready_p), ._tx(tx_p), ._busy(busy_p), ._done(done_p)
  );

  // Expected line level k cycles after the transfer edge (k = 1 is the first start-bit cycle).
  function automatic logic model_tx(input logic [7:0] l, input bit par, input int k);
    logic bits [0:10];
    int b;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = l[i];
    bits[9]  = par ? ^l : 1'b1;
    bits[10] = 1'b1;
    b = (k - 1) / CPB;
    if (k < 1 || b > 10) return 1'b1;
    return bits[b];
  endfunction

  function automatic int frame_len(input bit par);
    return (par ? 11 : 10) * CPB;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b1; valid_n = 1'b0; valid_p = 1'b0; letter = 8'h00;
    repeat (3) begin
      @(negedge clk);
      checks++; if (tx_n !== 1'b1)    begin errors++; $display("FAIL rst_tx got %b want 1", tx_n); end
      checks++; if (ready_n !== 1'b0) begin errors++; $display("FAIL rst_ready got %b want 0", ready_n); end
      checks++; if (busy_n !== 1'b0)  begin errors++; $display("FAIL rst_busy got %b want 0", busy_n); end
      checks++; if (done_n !== 1'b0)  begin errors++; $display("FAIL rst_done got %b want 0", done_n); end
    end
    rst_n = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      checks++; if (tx_n !== 1'b1)    begin errors++; $display("FAIL idle_tx c=%0d got %b want 1", c, tx_n); end
      checks++; if (ready_n !== 1'b1) begin errors++; $display("FAIL idle_ready c=%0d got %b want 1", c, ready_n); end
      checks++; if (busy_n !== 1'b0)  begin errors++; $display("FAIL idle_busy c=%0d got %b want 0", c, busy_n); end
      checks++; if (done_n !== 1'b0)  begin errors++; $display("FAIL idle_done c=%0d got %b want 0", c, done_n); end
    end
  endtask

  // Single frames on the no-parity DUT; first letter fixed, the rest random.
  task automatic test_single(input logic [7:0] first, input int n_frames);
    logic [7:0] l;
    int len;
    len = frame_len(1'b0);
    for (int n = 0; n < n_frames; n++) begin
      l = (n == 0) ? first : 8'($urandom_range(0, 255));
      letter = l; valid_n = 1'b1;
      checks++; if (ready_n !== 1'b1) begin errors++; $display("FAIL single_ready_idle got %b want 1", ready_n); end
      @(posedge clk); #1;
      valid_n = 1'b0;
      for (int k = 1; k <= len; k++) begin
        @(negedge clk);
        checks++; if (tx_n !== model_tx(l, 1'b0, k))
          begin errors++; $display("FAIL single_tx l=%h k=%0d got %b want %b", l, k, tx_n, model_tx(l, 1'b0, k)); end
        checks++; if (done_n !== (k == len))
          begin errors++; $display("FAIL single_done k=%0d got %b want %b", k, done_n, (k == len)); end
        checks++; if (busy_n !== 1'b1)
          begin errors++; $display("FAIL single_busy k=%0d got %b want 1", k, busy_n); end
        checks++; if (ready_n !== (k == len))
          begin errors++; $display("FAIL single_ready k=%0d got %b want %b", k, ready_n, (k == len)); end
        letter = 8'($urandom_range(0, 255));
      end
      @(negedge clk);
      checks++; if (busy_n !== 1'b0) begin errors++; $display("FAIL single_busy_end got %b want 0", busy_n); end
      checks++; if (tx_n !== 1'b1)   begin errors++; $display("FAIL single_tx_end got %b want 1", tx_n); end
      checks++; if (done_n !== 1'b0) begin errors++; $display("FAIL single_done_end got %b want 0", done_n); end
    end
  endtask

  task automatic test_parity(input logic [7:0] first, input int n_frames);
    logic [7:0] l;
    logic exp_par;
    int len;
    len = frame_len(1'b1);
    for (int n = 0; n < n_frames; n++) begin
      l = (n == 0) ? first : 8'($urandom_range(0, 255));
      exp_par = (($countones(l) % 2) == 1);
      letter = l; valid_p = 1'b1;
      checks++; if (ready_p !== 1'b1) begin errors++; $display("FAIL par_ready_idle got %b want 1", ready_p); end
      @(posedge clk); #1;
      valid_p = 1'b0;
      for (int k = 1; k <= len; k++) begin
        @(negedge clk);
        checks++; if (tx_p !== model_tx(l, 1'b1, k))
          begin errors++; $display("FAIL par_tx l=%h k=%0d got %b want %b", l, k, tx_p, model_tx(l, 1'b1, k)); end
        if (k == 9 * CPB + 1) begin
          checks++; if (tx_p !== exp_par)
            begin errors++; $display("FAIL par_bit l=%h got %b want %b", l, tx_p, exp_par); end
        end
        checks++; if (done_p !== (k == len))
          begin errors++; $display("FAIL par_done k=%0d got %b want %b", k, done_p, (k == len)); end
        checks++; if (busy_p !== 1'b1)
          begin errors++; $display("FAIL par_busy k=%0d got %b want 1", k, busy_p); end
        letter = 8'($urandom_range(0, 255));
      end
      @(negedge clk);
      checks++; if (busy_p !== 1'b0) begin errors++; $display("FAIL par_busy_end got %b want 0", busy_p); end
      checks++; if (tx_p !== 1'b1)   begin errors++; $display("FAIL par_tx_end got %b want 1", tx_p); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] l1, l2;
    logic exp;
    int len;
    len = frame_len(1'b0);
    for (int n = 0; n < 2; n++) begin
      l1 = (n == 0) ? 8'h65 : 8'($urandom_range(0, 255));
      l2 = (n == 0) ? 8'h6C : 8'($urandom_range(0, 255));
      letter = l1; valid_n = 1'b1;
      checks++; if (ready_n !== 1'b1) begin errors++; $display("FAIL b2b_ready_idle got %b want 1", ready_n); end
      @(posedge clk); #1;
      letter = l2;
      for (int k = 1; k <= 2 * len; k++) begin
        @(negedge clk);
        if (k == len + 1) begin
          valid_n = 1'b0;
          letter  = 8'($urandom_range(0, 255));
        end
        exp = (k <= len) ? model_tx(l1, 1'b0, k) : model_tx(l2, 1'b0, k - len);
        checks++; if (tx_n !== exp)
          begin errors++; $display("FAIL b2b_tx k=%0d got %b want %b", k, tx_n, exp); end
        checks++; if (busy_n !== 1'b1)
          begin errors++; $display("FAIL b2b_busy k=%0d got %b want 1", k, busy_n); end
        checks++; if (done_n !== (k == len || k == 2 * len))
          begin errors++; $display("FAIL b2b_done k=%0d got %b want %b", k, done_n, (k == len || k == 2 * len)); end
        checks++; if (ready_n !== (k == len || k == 2 * len))
          begin errors++; $display("FAIL b2b_ready k=%0d got %b want %b", k, ready_n, (k == len || k == 2 * len)); end
      end
      @(negedge clk);
      checks++; if (busy_n !== 1'b0) begin errors++; $display("FAIL b2b_busy_end got %b want 0", busy_n); end
      checks++; if (tx_n !== 1'b1)   begin errors++; $display("FAIL b2b_tx_end got %b want 1", tx_n); end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] l;
    l = 8'h41;
    letter = l; valid_n = 1'b1;
    @(posedge clk); #1;
    valid_n = 1'b0;
    for (int k = 1; k <= 4 * CPB + 2; k++) begin
      @(negedge clk);
      checks++; if (tx_n !== model_tx(l, 1'b0, k))
        begin errors++; $display("FAIL mid_tx k=%0d got %b want %b", k, tx_n, model_tx(l, 1'b0, k)); end
    end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (tx_n !== 1'b1)    begin errors++; $display("FAIL mid_async_tx got %b want 1", tx_n); end
    checks++; if (busy_n !== 1'b0)  begin errors++; $display("FAIL mid_async_busy got %b want 0", busy_n); end
    checks++; if (ready_n !== 1'b0) begin errors++; $display("FAIL mid_async_ready got %b want 0", ready_n); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      checks++; if (done_n !== 1'b0) begin errors++; $display("FAIL mid_after_done c=%0d got %b want 0", c, done_n); end
      checks++; if (tx_n !== 1'b1)   begin errors++; $display("FAIL mid_after_tx c=%0d got %b want 1", c, tx_n); end
    end
    test_single(8'h6F, 1);
  endtask

  task automatic test_enable_drop();
    logic [7:0] l;
    int len;
    l = 8'h21;
    len = frame_len(1'b0);
    enable = 1'b1; letter = l; valid_n = 1'b1;
    checks++; if (ready_n !== 1'b1) begin errors++; $display("FAIL en_ready_idle got %b want 1", ready_n); end
    @(posedge clk); #1;
    for (int k = 1; k <= len; k++) begin
      @(negedge clk);
      if (k == 2) enable = 1'b0;
      checks++; if (tx_n !== model_tx(l, 1'b0, k))
        begin errors++; $display("FAIL en_tx k=%0d got %b want %b", k, tx_n, model_tx(l, 1'b0, k)); end
      checks++; if (done_n !== (k == len))
        begin errors++; $display("FAIL en_done k=%0d got %b want %b", k, done_n, (k == len)); end
      checks++; if (ready_n !== 1'b0)
        begin errors++; $display("FAIL en_ready k=%0d got %b want 0", k, ready_n); end
    end
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      checks++; if (tx_n !== 1'b1)    begin errors++; $display("FAIL en_idle_tx c=%0d got %b want 1", c, tx_n); end
      checks++; if (busy_n !== 1'b0)  begin errors++; $display("FAIL en_idle_busy c=%0d got %b want 0", c, busy_n); end
      checks++; if (ready_n !== 1'b0) begin errors++; $display("FAIL en_idle_ready c=%0d got %b want 0", c, ready_n); end
    end
    valid_n = 1'b0;
    enable  = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single(8'h48, 4);
    test_parity(8'h57, 1);
    test_parity(8'h21, 2);
    test_back_to_back();
    test_reset_mid();
    test_enable_drop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/_uart_tx.md
# _uart_tx

Serial transmitter stage that sits directly downstream of the `_helloWorld` character generator. It accepts 8-bit ASCII letters over a valid/ready handshake and shifts each one out as an asynchronous serial frame: start bit, 8 data bits LSB first, optional even parity, one stop bit. It drives the board-level TX pin and reports frame completion upstream so the generator can advance its character index.

## Interface

**Parameters**
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit. Legal range is 2..65535.
- `PARITY_EN`, default 0: when 1, an even-parity bit is inserted between data bit 7 and the stop bit.

**Ports**
- `_clock`, input, 1: single clock. All state changes on its rising edge.
- `_reset`, input, 1: asynchronous, active-low reset.
- `_enable`, input, 1: permits acceptance of new letters. It does not abort a frame in flight.
- `_valid`, input, 1: upstream has a letter on `_letter`.
- `_letter`, input, 8: ASCII byte to send.
- `_ready`, output, 1: the block will accept `_letter` at this rising edge if `_valid` is high.
- `_tx`, output, 1: serial line. Idles high.
- `_busy`, output, 1: a frame is in progress.
- `_done`, output, 1: one-cycle pulse in the final cycle of the stop bit.

## Operation

- **Reset.** While `_reset` is low:
  - `_tx`=1, `_ready`=0, `_busy`=0, `_done`=0.
  - State is IDLE and all counters are 0.
  - This takes effect immediately and asynchronously, including mid-frame. The partial frame is discarded.
- **Handshake.**
  - A transfer occurs at a rising edge where `_valid & _ready`.
  - The block latches `_letter` into a shift register.
  - `_ready` is combinational: `_enable & (state==IDLE | last cycle of STOP)`.
- **States.**
  - IDLE → START on transfer.
  - START → DATA after `CLKS_PER_BIT` cycles.
  - DATA → PARITY (if `PARITY_EN`) or STOP after 8 bits.
  - PARITY → STOP after `CLKS_PER_BIT` cycles.
  - At the end of STOP: go to START if a transfer occurs in that cycle, otherwise IDLE.
- **Line value per state.**
  - START: `_tx`=0.
  - DATA: `_tx` = shift register bit 0; shift right once per bit period.
  - PARITY: `_tx` = XOR of the 8 latched bits.
  - STOP and IDLE: `_tx`=1.
- **Counters.**
  - Baud counter width is `$clog2(CLKS_PER_BIT)`. It counts 0..`CLKS_PER_BIT`-1, wraps to 0, and emits a bit-end tick at terminal count.
  - Bit counter is 3 bits and counts 0..7.
  - The baud counter restarts at 0 on every transfer.
- **`_busy`.** High from the cycle after a transfer through the last STOP cycle. It stays high across back-to-back frames.
- **`_enable` low mid-frame.** The current frame completes normally, including `_done`. No new transfer is accepted.
- **`_valid` low.** The block stays in IDLE with `_tx`=1 indefinitely.
- **Input stability.** `_letter` changes after a transfer have no effect on the frame in flight.

## Timing

- **Latency.** Transfer at edge N puts `_tx`=0 after edge N. The start bit occupies cycles N+1..N+`CLKS_PER_BIT`.
- **Frame length.** `10*CLKS_PER_BIT` cycles, or `11*CLKS_PER_BIT` with parity.
- **`_done`.** High for exactly one cycle: the final cycle of STOP, coincident with `_ready` high when `_enable`=1.
- **Throughput.** With `_valid` held high, frames are back-to-back with no idle cycles between the stop bit and the next start bit.
- **Registered outputs.** `_tx`, `_busy` and `_done` are glitch-free register outputs. `_tx` must never be combinational.

## Structure

- **Shared package `_uart_pkg`:**
  - State enum: IDLE, START, DATA, PARITY, STOP.
  - Constants: `UART_DATA_BITS`=8, `UART_IDLE_LEVEL`=1'b1.
  - This package is reused by a future `_uart_rx`.
- **One sub-module: `_baud_tick`.**
  - Parameterized by `CLKS_PER_BIT`.
  - Inputs: `_clock`, `_reset`, synchronous clear.
  - Output: a one-cycle tick at terminal count.
- **Top level:** FSM, shift register, bit counter, parity accumulator.

## Test plan

- **Reset.** Hold `_reset` low for 3 cycles, then release with `_valid`=0 → `_tx`=1, `_ready`=1 (with `_enable`=1), `_busy`=0, `_done`=0 for 100 cycles.
- **Single frame, no parity.** `CLKS_PER_BIT`=4, `PARITY_EN`=0. Send 0x48 ('H') → `_tx` sequence per 4-cycle bit is 0, 0,0,0,1,0,0,1,0, 1. `_done` pulses at cycle 40 after the transfer.
- **Back-to-back frames.** Hold `_valid` high and send 0x65 then 0x6C → the second start bit begins in the cycle immediately after the first stop bit. `_busy` stays high for 80 cycles, and `_done` pulses twice, 40 cycles apart.
- **Parity.** `PARITY_EN`=1. Send 0x57 ('W') → parity bit is 1 and the frame is 44 cycles. Send 0x21 ('!') → parity bit is 0.
- **Reset mid-frame.** Assert `_reset` low during DATA bit 3 → `_tx`=1 immediately without waiting for a clock edge. After release, no `_done` occurs and the next frame for 0x6F is sent correctly.
- **Enable dropped mid-frame.** Deassert `_enable` during START → the frame for 0x21 completes with `_done`. `_ready` stays 0 and no further frame starts while `_valid`=1.
